// File: rtl/key_conditioner_if.sv
// Pushbutton bundle between the board KEY pins and the conditioned level/pulse outputs.
// The master side drives the raw keys; the slave side is key_conditioner.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, counter debouncer and registered press/release pulse generator.
// Optional auto-repeat of key_press while held is enabled by defining KEYCOND_REPEAT_EN.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int RPT_W           = 25
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  key_conditioner_if.slave keys
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W) ||
      REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD ||
      (REPEAT_DELAY - 1) >= (1 << RPT_W)) begin : g_param_check
    $error("key_conditioner: illegal parameter combination");
  end

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] s;

  logic [1:0]       state_q [NUM_KEYS];
  logic [1:0]       state_d [NUM_KEYS];
  logic [CNT_W-1:0] cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0] cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q,   rel_d;

`ifdef KEYCOND_REPEAT_EN
  // The reload value makes every later repeat land REPEAT_PERIOD cycles after the previous one.
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  logic [RPT_W-1:0] rpt_q [NUM_KEYS];
  logic [RPT_W-1:0] rpt_d [NUM_KEYS];
`endif

  assign s = ~sync2;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
`ifdef KEYCOND_REPEAT_EN
      rpt_d[i]   = '0;
`endif
      case (state_q[i])
        ST_IDLE: begin
          if (s[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = ST_PRESS_PEND;
          end
        end
        ST_PRESS_PEND: begin
          if (!s[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_PRESSED;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = ST_REL_PEND;
          end else begin
`ifdef KEYCOND_REPEAT_EN
            // Repeat only while the key is solidly held; any release attempt clears it.
            if (rpt_q[i] == RPT_LAST) begin
              rpt_d[i]   = RPT_RELOAD;
              press_d[i] = 1'b1;
            end else begin
              rpt_d[i]   = rpt_q[i] + RPT_ONE;
            end
`endif
          end
        end
        ST_REL_PEND: begin
          if (s[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1   <= '1;
      sync2   <= '1;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
`ifdef KEYCOND_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      sync1   <= keys.key_n;
      sync2   <= sync1;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef KEYCOND_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = rel_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_conditioner;

  logic CLOCK_50;
  logic reset;
  int   checks;
  int   errors;

  key_conditioner_if #(.NUM_KEYS(4)) kif ();

  key_conditioner #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .RPT_W(5)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .keys(kif)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle_idle();
    kif.key_n = 4'b1111;
    for (int e = 0; e < 12; e++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] el, ep, er;
    reset = 1'b1;
    kif.key_n = 4'b0000;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (kif.key_level !== 4'b0000 || kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_hold edge %0d level=%b press=%b release=%b required 0000",
                 e, kif.key_level, kif.key_press, kif.key_release);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      el = (e >= 6) ? 4'b1111 : 4'b0000;
      ep = (e == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (kif.key_level !== el) begin
        errors++;
        $display("[TB] FAIL reset_level edge %0d got %b required %b", e, kif.key_level, el);
      end
      checks++;
      if (kif.key_press !== ep) begin
        errors++;
        $display("[TB] FAIL reset_press edge %0d got %b required %b", e, kif.key_press, ep);
      end
    end
    kif.key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      el = (e < 6) ? 4'b1111 : 4'b0000;
      er = (e == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_release !== er || kif.key_press !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_release edge %0d level=%b press=%b release=%b required %b/0000/%b",
                 e, kif.key_level, kif.key_press, kif.key_release, el, er);
      end
    end
    settle_idle();
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep, er;
    kif.key_n = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      tick();
      el = (e >= 6) ? 4'b0010 : 4'b0000;
      ep = (e == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL clean_press edge %0d level=%b press=%b release=%b required %b/%b/0000",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep);
      end
    end
    kif.key_n = 4'b1111;
    for (int e = 1; e <= 20; e++) begin
      tick();
      el = (e < 6) ? 4'b0010 : 4'b0000;
      er = (e == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== 4'b0000 || kif.key_release !== er) begin
        errors++;
        $display("[TB] FAIL clean_release edge %0d level=%b press=%b release=%b required %b/0000/%b",
                 e, kif.key_level, kif.key_press, kif.key_release, el, er);
      end
    end
    settle_idle();
  endtask

  task automatic test_glitch();
    logic [3:0] el, ep, er;
    for (int e = 1; e <= 12; e++) begin
      kif.key_n = (e <= 3) ? 4'b1011 : 4'b1111;
      tick();
      checks++;
      if (kif.key_level !== 4'b0000 || kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL glitch3 edge %0d level=%b press=%b release=%b required 0000",
                 e, kif.key_level, kif.key_press, kif.key_release);
      end
    end
    for (int e = 1; e <= 16; e++) begin
      kif.key_n = (e <= 4) ? 4'b1011 : 4'b1111;
      tick();
      el = (e >= 6 && e < 10) ? 4'b0100 : 4'b0000;
      ep = (e == 6)  ? 4'b0100 : 4'b0000;
      er = (e == 10) ? 4'b0100 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== er) begin
        errors++;
        $display("[TB] FAIL glitch4 edge %0d level=%b press=%b release=%b required %b/%b/%b",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep, er);
      end
    end
    settle_idle();
  endtask

  task automatic test_bounce();
    logic [3:0] el, ep;
    for (int e = 1; e <= 16; e++) begin
      kif.key_n = (e == 2 || e == 4) ? 4'b1111 : 4'b1110;
      tick();
      el = (e >= 10) ? 4'b0001 : 4'b0000;
      ep = (e == 10) ? 4'b0001 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bounce edge %0d level=%b press=%b release=%b required %b/%b/0000",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep);
      end
    end
    settle_idle();
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] el, ep;
    kif.key_n = 4'b0111;
    for (int e = 1; e <= 14; e++) begin
      reset = (e == 3);
      tick();
      el = (e >= 9) ? 4'b1000 : 4'b0000;
      ep = (e == 9) ? 4'b1000 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_mid_count edge %0d level=%b press=%b release=%b required %b/%b/0000",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep);
      end
    end
    reset = 1'b0;
    settle_idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] el, ep;
    for (int e = 1; e <= 12; e++) begin
      kif.key_n = (e >= 3) ? 4'b1010 : 4'b1110;
      tick();
      el = {1'b0, (e >= 8), 1'b0, (e >= 6)};
      ep = {1'b0, (e == 8), 1'b0, (e == 6)};
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL back_to_back edge %0d level=%b press=%b release=%b required %b/%b/0000",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep);
      end
    end
    settle_idle();
  endtask

  task automatic test_repeat();
    logic [3:0] el, ep, er;
    logic       rpt;
    for (int e = 1; e <= 45; e++) begin
      kif.key_n = (e <= 30) ? 4'b1110 : 4'b1111;
      tick();
`ifdef KEYCOND_REPEAT_EN
      rpt = (e >= 16 && e <= 31 && ((e - 16) % 3) == 0);
`else
      rpt = 1'b0;
`endif
      el = (e >= 6 && e < 36) ? 4'b0001 : 4'b0000;
      ep = (e == 6 || rpt) ? 4'b0001 : 4'b0000;
      er = (e == 36) ? 4'b0001 : 4'b0000;
      checks++;
      if (kif.key_level !== el || kif.key_press !== ep || kif.key_release !== er) begin
        errors++;
        $display("[TB] FAIL repeat edge %0d level=%b press=%b release=%b required %b/%b/%b",
                 e, kif.key_level, kif.key_press, kif.key_release, el, ep, er);
      end
    end
    settle_idle();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    kif.key_n = 4'b1111;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_reset_mid_count();
    test_back_to_back();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
